// File: rtl/urv_defs.sv
// urv_defs: register map and CTRL bit layout shared by uRV timer peripherals.
package urv_defs;
  localparam logic [1:0] TIMER_CMP_LO = 2'd0;
  localparam logic [1:0] TIMER_CMP_HI = 2'd1;
  localparam logic [1:0] TIMER_CTRL   = 2'd2;
  localparam logic [1:0] TIMER_PERIOD = 2'd3;
  localparam int TIMER_CTRL_EN   = 0;
  localparam int TIMER_CTRL_PER  = 1;
  localparam int TIMER_CTRL_IE   = 2;
  localparam int TIMER_CTRL_PEND = 3;
  localparam int TIMER_CTRL_OVR  = 4;
endpackage

// File: rtl/urv_timer_cmp.sv
// urv_timer_cmp: machine-timer compare unit with one-shot and auto-reload modes.
module urv_timer_cmp
  import urv_defs::*;
#(
  parameter int g_time_width = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_time_width-1:0] time_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [1:0]              addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic                    ack_o,
  output logic                    irq_o
);
  logic [g_time_width-1:0] cmp_q;
  logic [31:0] shadow_q, period_q, rdata_q;
  logic en_q, per_q, ie_q, pend_q, ovr_q, armed_q, ack_q;
  logic match, commit, wr_ctrl;
  logic [31:0] rd_mux;

  assign match   = en_q && armed_q && (time_i >= cmp_q);
  assign commit  = wr_i && addr_i == TIMER_CMP_HI;
  assign wr_ctrl = wr_i && addr_i == TIMER_CTRL;
  assign rd_mux  = addr_i == TIMER_CMP_LO ? cmp_q[31:0] :
                   addr_i == TIMER_CMP_HI ? 32'(cmp_q[g_time_width-1:32]) :
                   addr_i == TIMER_CTRL   ? {27'd0, ovr_q, pend_q, ie_q, per_q, en_q} :
                   period_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cmp_q    <= '1;
      shadow_q <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      per_q    <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      armed_q  <= 1'b1;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= wr_i | rd_i;
      if (rd_i) rdata_q <= rd_mux;
      if (wr_i && addr_i == TIMER_CMP_LO) shadow_q <= wdata_i;
      if (wr_i && addr_i == TIMER_PERIOD) period_q <= wdata_i;
      if (wr_ctrl) begin
        en_q  <= wdata_i[TIMER_CTRL_EN];
        per_q <= wdata_i[TIMER_CTRL_PER];
        ie_q  <= wdata_i[TIMER_CTRL_IE];
        if (wdata_i[TIMER_CTRL_PEND]) pend_q <= 1'b0;
        if (wdata_i[TIMER_CTRL_OVR]) ovr_q <= 1'b0;
      end
      // A commit discards any fire against the old compare value
      if (commit) begin
        cmp_q   <= {wdata_i[g_time_width-33:0], shadow_q};
        armed_q <= 1'b1;
      end else if (match) begin
        pend_q <= 1'b1;
        if (pend_q && !(wr_ctrl && wdata_i[TIMER_CTRL_PEND])) ovr_q <= 1'b1;
        if (per_q && period_q != '0) cmp_q <= cmp_q + g_time_width'(period_q);
        else armed_q <= 1'b0;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign irq_o   = pend_q & ie_q;
endmodule

// File: tb/tb_urv_timer_cmp.sv
// tb_urv_timer_cmp: directed self-checking bench for the timer compare unit.
module tb_urv_timer_cmp;
  logic clk, rst_n, wr, rd, ack, irq;
  logic [39:0] tm;
  logic [1:0] addr;
  logic [31:0] wdata, rdata, r;
  int total = 0;
  int bad = 0;

  urv_timer_cmp #(.g_time_width(40)) dut (
    .clk_i(clk), .rst_i(rst_n), .time_i(tm), .wr_i(wr), .rd_i(rd),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rreg(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    d = rdata;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = '0; tm = '0;
    #12;
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rreg(2'd0, r); check("rst_cmp_lo", r, 32'hFFFF_FFFF);
    rreg(2'd1, r); check("rst_cmp_hi", r, 32'hFF);
    rreg(2'd2, r); check("rst_ctrl", r, 0);
    rreg(2'd3, r); check("rst_period", r, 0);

    // read path timing: ack only in the cycle after the strobe, rdata holds
    tick();
    check("ack_idle", ack, 0);
    addr = 2'd1; rd = 1'b1;
    #3; check("ack_early", ack, 0);
    tick(); rd = 1'b0;
    check("ack_rd", ack, 1);
    check("rdata_rd", rdata, 32'hFF);
    tick();
    check("ack_drop", ack, 0);
    check("rdata_hold", rdata, 32'hFF);

    // one-shot
    wreg(2'd0, 100); wreg(2'd1, 0);
    check("ack_wr", ack, 1);
    wreg(2'd2, 32'h5);
    for (int t = 97; t <= 103; t++) begin
      tm = 40'(t);
      tick();
      check($sformatf("oneshot_t%0d", t), irq, t >= 100);
    end
    wreg(2'd2, 32'h0D);
    check("oneshot_w1c", irq, 0);
    for (int t = 104; t <= 107; t++) begin
      tm = 40'(t);
      tick();
    end
    check("oneshot_norefire", irq, 0);
    rreg(2'd2, r); check("oneshot_ctrl", r, 32'h5);

    // periodic
    tm = 0;
    wreg(2'd3, 20); wreg(2'd0, 50); wreg(2'd1, 0); wreg(2'd2, 32'h7);
    tm = 49; tick(); check("per_49", irq, 0);
    tm = 50; tick(); check("per_50", irq, 1);
    wreg(2'd2, 32'h0F); check("per_clr1", irq, 0);
    tm = 69; tick(); check("per_69", irq, 0);
    tm = 70; tick(); check("per_70", irq, 1);
    wreg(2'd2, 32'h0F); check("per_clr2", irq, 0);
    tm = 90; tick(); check("per_90", irq, 1);
    rreg(2'd0, r); check("per_cmp110", r, 110);
    rreg(2'd2, r); check("per_ctrl_noovr", r, 32'h0F);

    // overrun and catch-up: fires at cmp 10..40, ends at 45
    wreg(2'd2, 32'h18);
    tm = 40;
    wreg(2'd3, 5); wreg(2'd0, 10); wreg(2'd1, 0);
    wreg(2'd2, 32'h7);
    rreg(2'd2, r); check("ovr_before", r, 32'h07);
    rreg(2'd2, r); check("ovr_fire1", r, 32'h0F);
    rreg(2'd2, r); check("ovr_fire2", r, 32'h1F);
    rreg(2'd0, r); check("ovr_cmp_mid", r, 25);
    repeat (8) tick();
    rreg(2'd0, r); check("ovr_cmp45", r, 45);
    rreg(2'd2, r); check("ovr_ctrl", r, 32'h1F);

    // atomic commit
    wreg(2'd2, 32'h18);
    wreg(2'd0, 32'hFFFF_FFFF); wreg(2'd1, 32'hFF);
    tm = 1000;
    wreg(2'd2, 32'h5);
    wreg(2'd0, 500);
    repeat (3) tick();
    check("lo_only_irq", irq, 0);
    rreg(2'd0, r); check("lo_only_cmp", r, 32'hFFFF_FFFF);
    tm = 40'hFF_FFFF_FFFF;
    wreg(2'd1, 0);
    check("commit_pend", irq, 0);
    tick();
    check("commit_fire", irq, 1);
    rreg(2'd0, r); check("commit_cmp", r, 500);

    // asynchronous reset between edges
    #2; rst_n = 1'b0;
    #1; check("arst_irq", irq, 0);
    check("arst_ack", ack, 0);
    #1; rst_n = 1'b1;
    tm = 0;
    tick();
    rreg(2'd0, r); check("arst_cmp_lo", r, 32'hFFFF_FFFF);
    rreg(2'd1, r); check("arst_cmp_hi", r, 32'hFF);
    rreg(2'd2, r); check("arst_ctrl", r, 0);

    // unused CTRL bits read zero
    wreg(2'd2, 32'hFFFF_FFE7);
    rreg(2'd2, r); check("ctrl_unused", r, 32'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
